// File: rtl/regfile_debug_scan_pkg.sv
// Shared constants for the register-file debug scan: FSM state encoding,
// bytes per word and the debug register count.
package regfile_debug_scan_pkg;

    localparam int BYTES_PER_WORD_C = 4;
    localparam int DEBUG_REGS       = 32;
    localparam int REG_AW           = $clog2(DEBUG_REGS);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_HALT   = 3'd1;
    localparam state_t ST_LATCH  = 3'd2;
    localparam state_t ST_SEND   = 3'd3;
    localparam state_t ST_FINISH = 3'd4;
    localparam state_t ST_PCWORD = 3'd5;

endpackage

// File: rtl/regfile_debug_scan_word_byte_serializer.sv
// Word-to-byte serializer: loads one word and presents its bytes MSB first
// over a valid/ready handshake, flagging the final byte with last.
module word_byte_serializer #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [8*BYTES-1:0] word,
    input  logic               enable,
    input  logic               ready,
    output logic [7:0]         data,
    output logic               valid,
    output logic               last
);

    localparam int             CW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(BYTES - 1);

    logic [8*BYTES-1:0] word_q;
    logic [CW-1:0]      idx_q;
    logic [8*BYTES-1:0] shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word;
            idx_q  <= '0;
        end else if (enable && ready) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    // The index only advances on a handshake, so data holds while stalled.
    assign shifted = word_q << (8 * idx_q);
    assign valid   = enable;
    assign last    = (idx_q == LAST_IDX);
    assign data    = enable ? shifted[8*BYTES-1 -: 8] : 8'h00;

endmodule

// File: rtl/regfile_debug_scan.sv
// Freezes the pipeline and streams registers 0..NUM_REGS-1 as MSB-first bytes.
// Optional macro DEBUG_SCAN_PC_EN prepends the current PC as one extra word.
module regfile_debug_scan
    import regfile_debug_scan_pkg::*;
#(
    parameter int NUM_REGS       = DEBUG_REGS,
    parameter int BYTES_PER_WORD = BYTES_PER_WORD_C
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic              Debug_on,
    output logic [REG_AW-1:0] Debug_read_reg,
    input  logic [31:0]       regDebug,
    input  logic [31:0]       pc_value,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

    state_t      state_q;
    state_t      state_d;
    logic        ser_load;
    logic        ser_enable;
    logic        ser_last;
    logic [31:0] ser_word;
    logic        word_done;

    assign word_done = tx_valid && tx_ready && ser_last;

`ifdef DEBUG_SCAN_PC_EN
    assign ser_load = (state_q == ST_LATCH) || ((state_q == ST_HALT) && halt_ack);
    assign ser_word = (state_q == ST_LATCH) ? regDebug : pc_value;
`else
    logic unused_pc;
    assign unused_pc = ^pc_value;
    assign ser_load  = (state_q == ST_LATCH);
    assign ser_word  = regDebug;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_HALT;
`ifdef DEBUG_SCAN_PC_EN
            ST_HALT:   if (halt_ack) state_d = ST_PCWORD;
`else
            ST_HALT:   if (halt_ack) state_d = ST_LATCH;
`endif
            ST_PCWORD: if (word_done) state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_SEND;
            ST_SEND: begin
                if (word_done)
                    state_d = (Debug_read_reg == LAST_REG) ? ST_FINISH : ST_LATCH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Restarting from register 0 on every accepted start discards any aborted dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Debug_read_reg <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            Debug_read_reg <= '0;
        end else if ((state_q == ST_SEND) && word_done && (Debug_read_reg != LAST_REG)) begin
            Debug_read_reg <= Debug_read_reg + 1'b1;
        end
    end

    assign ser_enable = (state_q == ST_SEND) || (state_q == ST_PCWORD);

    word_byte_serializer #(
        .BYTES (BYTES_PER_WORD)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load   (ser_load),
        .word   (ser_word),
        .enable (ser_enable),
        .ready  (tx_ready),
        .data   (tx_data),
        .valid  (tx_valid),
        .last   (ser_last)
    );

    assign halt_req = (state_q == ST_HALT) || (state_q == ST_PCWORD) ||
                      (state_q == ST_LATCH) || (state_q == ST_SEND);
    assign Debug_on = (state_q == ST_LATCH) || (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);

endmodule
